regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the core's 2-read/1-write regfile.
- Configurable read-port count and two write ports. Optional hardwired-zero register 0.
- Per-register pending (scoreboard) bit so the pipeline can stall on outstanding producers.
- Multi-cycle sweep-clear FSM that re-initialises the file without asserting arstn. Sits between decode (reads, pending set) and writeback (writes).

---
 rtl/regfile_mp.sv | 149 ++++++++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, pending scoreboard bits and sweep clear.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
`default_nettype none

module regfile_mp #(
    parameter int REGS_NUM   = 32,
    parameter int REGS_WIDTH = 32,
    parameter int RD_PORTS   = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = $clog2(REGS_NUM)
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           we0,
    input  logic [AW-1:0]                  waddr0,
    input  logic [REGS_WIDTH-1:0]          wdata0,
    input  logic                           we1,
    input  logic [AW-1:0]                  waddr1,
    input  logic [REGS_WIDTH-1:0]          wdata1,
    input  logic [RD_PORTS*AW-1:0]         ra,
    output logic [RD_PORTS*REGS_WIDTH-1:0] rd,
    output logic [RD_PORTS-1:0]            rd_pend,
    input  logic                           set_pend,
    input  logic [AW-1:0]                  pend_addr,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [REGS_WIDTH-1:0]          r_last
);

    localparam logic [AW:0]   NREGS = (AW+1)'(REGS_NUM);
    localparam logic [AW-1:0] LAST  = AW'(REGS_NUM - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [AW-1:0]           idx;
    logic [REGS_WIDTH-1:0]   regs [REGS_NUM];
    logic [REGS_NUM-1:0]     pend;
    logic [REGS_NUM-1:0]     pend_nx;
    logic                    w0_en;
    logic                    w1_en;
    logic                    set_en;

    // Out-of-range addresses and the hardwired zero register never hold state.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w0_en    = (state == IDLE) && we0 && addr_ok(waddr0);
    assign w1_en    = (state == IDLE) && we1 && addr_ok(waddr1);
    assign set_en   = (state == IDLE) && set_pend && addr_ok(pend_addr);
    assign clr_busy = (state == CLEAR);
    assign r_last   = regs[REGS_NUM-1];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clr_req) state_nx = CLEAR;
            CLEAR:   if (idx == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (clr_req) idx <= '0;
            end else begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Write port 1 is checked first so it wins a same-address collision.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < REGS_NUM; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REGS_NUM; i++) begin
                if (state == CLEAR) begin
                    if (idx == AW'(i)) regs[i] <= '0;
                end else if (w1_en && (waddr1 == AW'(i))) begin
                    regs[i] <= wdata1;
                end else if (w0_en && (waddr0 == AW'(i))) begin
                    regs[i] <= wdata0;
                end
            end
        end
    end

    // Set is applied after the write clears so a colliding set leaves the bit high.
    always_comb begin
        pend_nx = pend;
        if (state == IDLE) begin
            if (clr_req) begin
                pend_nx = '0;
            end else begin
                if (w0_en)  pend_nx[waddr0]    = 1'b0;
                if (w1_en)  pend_nx[waddr1]    = 1'b0;
                if (set_en) pend_nx[pend_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) pend <= '0;
        else        pend <= pend_nx;
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [AW-1:0]         a;
        logic [REGS_WIDTH-1:0] dat;
        logic                  pnd;

        assign a = ra[k*AW +: AW];

        always_comb begin
            dat = '0;
            pnd = 1'b0;
            if (addr_ok(a)) begin
                dat = regs[a];
                pnd = pend[a];
`ifdef REGFILE_BYPASS_EN
                if (w1_en && (waddr1 == a)) begin
                    dat = wdata1;
                    pnd = set_en && (pend_addr == a);
                end else if (w0_en && (waddr0 == a)) begin
                    dat = wdata0;
                    pnd = set_en && (pend_addr == a);
                end
`endif
            end
        end

        assign rd[k*REGS_WIDTH +: REGS_WIDTH] = dat;
        assign rd_pend[k]                     = pnd;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (default parameters, 2 read ports).
`default_nettype none

module tb_regfile_mp;

    localparam int N  = 32;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int RP = 2;
`ifdef REGFILE_BYPASS_EN
    localparam logic [W-1:0] BYP_NOW = 32'h0000CAFE;
`else
    localparam logic [W-1:0] BYP_NOW = 32'h00001234;
`endif

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic            we0, we1, set_pend, clr_req;
    logic [AW-1:0]   waddr0, waddr1, pend_addr;
    logic [W-1:0]    wdata0, wdata1;
    logic [RP*AW-1:0] ra;
    logic [RP*W-1:0] rd;
    logic [RP-1:0]   rd_pend;
    logic            clr_busy;
    logic [W-1:0]    r_last;

    regfile_mp dut (
        .clk       (clk),
        .arstn     (arstn),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .ra        (ra),
        .rd        (rd),
        .rd_pend   (rd_pend),
        .set_pend  (set_pend),
        .pend_addr (pend_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .r_last    (r_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [W-1:0] data;
        logic         pend;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cnt;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [AW-1:0] addr,
                             input logic [W-1:0] data, input logic pend);
        exp_t e;
        ra[port*AW +: AW] = addr;
        e.port = port;
        e.data = data;
        e.pend = pend;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_d"}, rd[e.port*W +: W], e.data);
            check({t, "_p"}, W'(rd_pend[e.port]), W'(e.pend));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        we0 = 0; we1 = 0; set_pend = 0; clr_req = 0;
        waddr0 = '0; waddr1 = '0; pend_addr = '0;
        wdata0 = '0; wdata1 = '0; ra = '0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;

        check("rst_busy", W'(clr_busy), '0);
        check("rst_last", r_last, '0);
        expect_rd("rst_p0", 0, 5, '0, 0);
        expect_rd("rst_p1", 1, 5, '0, 0);
        drain();

        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        tick(); we0 = 0;
        expect_rd("wr5_p0", 0, 5, 32'hDEADBEEF, 0);
        expect_rd("wr5_p1", 1, 5, 32'hDEADBEEF, 0);
        drain();

        we0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22222222;
        tick(); we0 = 0; we1 = 0;
        expect_rd("coll7", 0, 7, 32'h22222222, 0);
        drain();

        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
        set_pend = 1; pend_addr = 0;
        tick(); we0 = 0; set_pend = 0;
        expect_rd("zero0", 1, 0, '0, 0);
        drain();

        set_pend = 1; pend_addr = 3;
        tick(); set_pend = 0;
        expect_rd("pend3", 0, 3, '0, 1);
        drain();
        we0 = 1; waddr0 = 3; wdata0 = 32'h55;
        tick(); we0 = 0;
        expect_rd("wr3", 0, 3, 32'h55, 0);
        drain();

        set_pend = 1; pend_addr = 9;
        we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        tick(); set_pend = 0; we1 = 0;
        expect_rd("setwin9", 1, 9, 32'h99, 1);
        drain();

        for (int i = 1; i < N; i++) begin
            we0 = 1; waddr0 = AW'(i); wdata0 = W'(i);
            tick();
        end
        we0 = 0;
        check("fill_last", r_last, 32'd31);

        clr_req = 1;
        tick(); clr_req = 0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            if (cnt == 2) begin
                expect_rd("sweep_vis", 0, 20, 32'd20, 0);
                drain();
            end
            if (cnt == 10) begin
                we0 = 1; waddr0 = 4; wdata0 = 32'hABCD;
            end else begin
                we0 = 0;
            end
            cnt++;
            tick();
        end
        we0 = 0;
        check("sweep_len", W'(cnt), 32'd32);
        check("sweep_last", r_last, '0);
        for (int i = 0; i < N/2; i++) begin
            expect_rd("post_clr", 0, AW'(2*i), '0, 0);
            expect_rd("post_clr", 1, AW'(2*i+1), '0, 0);
            drain();
        end

        we0 = 1; waddr0 = 31; wdata0 = 32'h31;
        we1 = 1; waddr1 = 5;  wdata1 = 32'h5;
        tick(); we0 = 0; we1 = 0;
        check("pre_rst_last", r_last, 32'h31);
        clr_req = 1;
        tick(); clr_req = 0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 10) begin
            cnt++;
            tick();
        end
        arstn = 1'b0;
        #1;
        check("mid_rst_busy", W'(clr_busy), '0);
        check("mid_rst_last", r_last, '0);
        expect_rd("mid_rst5", 0, 5, '0, 0);
        expect_rd("mid_rst9", 1, 9, '0, 0);
        drain();
        tick(); arstn = 1'b1;

        clr_req = 1;
        tick(); clr_req = 0;
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("resweep_len", W'(cnt), 32'd32);

        we0 = 1; waddr0 = 2; wdata0 = 32'h1234;
        tick(); we0 = 0;
        we1 = 1; waddr1 = 2; wdata1 = 32'hCAFE;
        expect_rd("byp_now", 0, 2, BYP_NOW, 0);
        drain();
        tick(); we1 = 0;
        expect_rd("byp_next", 0, 2, 32'hCAFE, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
